// File: rtl/mesi_isc_broad_multi_if.sv
// Bus bundle for mesi_isc_broad_multi: broadcast request push, per-CPU coherence
// commands/acks and FIFO/completion status.
interface mesi_isc_broad_multi_if #(
  parameter int CBUS_CMD_WIDTH   = 3,
  parameter int ADDR_WIDTH       = 32,
  parameter int BROAD_TYPE_WIDTH = 2,
  parameter int BROAD_ID_WIDTH   = 5,
  parameter int NUM_CPUS         = 4,
  parameter int CPU_ID_WIDTH     = 2,
  parameter int FIFO_DEPTH_LOG2  = 2
);
  logic [NUM_CPUS-1:0]                cbus_ack_array_i;
  logic                               broad_fifo_wr_i;
  logic [ADDR_WIDTH-1:0]              broad_addr_i;
  logic [BROAD_TYPE_WIDTH-1:0]        broad_type_i;
  logic [CPU_ID_WIDTH-1:0]            broad_cpu_id_i;
  logic [BROAD_ID_WIDTH-1:0]          broad_id_i;
  logic [ADDR_WIDTH-1:0]              cbus_addr_o;
  logic [NUM_CPUS*CBUS_CMD_WIDTH-1:0] cbus_cmd_array_o;
  logic                               fifo_status_full_o;
  logic                               fifo_status_almost_full_o;
  logic [FIFO_DEPTH_LOG2:0]           fifo_count_o;
  logic                               broad_done_o;
  logic [BROAD_ID_WIDTH-1:0]          broad_done_id_o;
  logic                               timeout_err_o;

  modport master (
    output cbus_ack_array_i, broad_fifo_wr_i, broad_addr_i, broad_type_i,
           broad_cpu_id_i, broad_id_i,
    input  cbus_addr_o, cbus_cmd_array_o, fifo_status_full_o,
           fifo_status_almost_full_o, fifo_count_o, broad_done_o,
           broad_done_id_o, timeout_err_o
  );

  modport slave (
    input  cbus_ack_array_i, broad_fifo_wr_i, broad_addr_i, broad_type_i,
           broad_cpu_id_i, broad_id_i,
    output cbus_addr_o, cbus_cmd_array_o, fifo_status_full_o,
           fifo_status_almost_full_o, fifo_count_o, broad_done_o,
           broad_done_id_o, timeout_err_o
  );
endinterface

// File: rtl/mesi_isc_broad_multi.sv
// Broadcast unit: request FIFO, snoop of all non-initiating CPUs, then grant to initiator.
// Optional acknowledge timeout enabled by defining MESI_ISC_BROAD_ACK_TIMEOUT_EN.
module mesi_isc_broad_multi #(
  parameter int CBUS_CMD_WIDTH   = 3,
  parameter int ADDR_WIDTH       = 32,
  parameter int BROAD_TYPE_WIDTH = 2,
  parameter int BROAD_ID_WIDTH   = 5,
  parameter int NUM_CPUS         = 4,
  parameter int CPU_ID_WIDTH     = 2,
  parameter int FIFO_DEPTH       = 4,
  parameter int FIFO_DEPTH_LOG2  = 2,
  parameter int ALMOST_FULL_LVL  = 3,
  parameter int ACK_TIMEOUT      = 255
) (
  input logic clk,
  input logic rst,
  mesi_isc_broad_multi_if.slave bus
);
  // state    | meaning
  // ST_IDLE  | waiting for a FIFO head entry
  // ST_SNOOP | snoop commands to every CPU not yet in the ack mask
  // ST_GRANT | write/read enable to the initiator, waiting for its ack
  // ST_POP   | retire head entry, done pulse
  typedef enum logic [1:0] {ST_IDLE, ST_SNOOP, ST_GRANT, ST_POP} state_t;

  localparam int CW = FIFO_DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_CNT  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ALMOST_CNT = CW'(ALMOST_FULL_LVL);
  localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_WR = BROAD_TYPE_WIDTH'(1);
  localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_RD = BROAD_TYPE_WIDTH'(2);
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_WR_SNOOP = CBUS_CMD_WIDTH'(1);
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_RD_SNOOP = CBUS_CMD_WIDTH'(2);
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_WR    = CBUS_CMD_WIDTH'(3);
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_RD    = CBUS_CMD_WIDTH'(4);

  if (NUM_CPUS < 2 || NUM_CPUS > 16 || (1 << FIFO_DEPTH_LOG2) != FIFO_DEPTH ||
      (1 << CPU_ID_WIDTH) < NUM_CPUS || ACK_TIMEOUT < 1) begin : g_bad_params
    $error("mesi_isc_broad_multi: illegal parameter set");
  end

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0]       fifo_addr [FIFO_DEPTH];
  logic [BROAD_TYPE_WIDTH-1:0] fifo_type [FIFO_DEPTH];
  logic [CPU_ID_WIDTH-1:0]     fifo_cpu  [FIFO_DEPTH];
  logic [BROAD_ID_WIDTH-1:0]   fifo_id   [FIFO_DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]               count;
  logic fifo_empty, fifo_full, fifo_push, fifo_pop;

  logic [ADDR_WIDTH-1:0]       head_addr;
  logic [BROAD_TYPE_WIDTH-1:0] head_type;
  logic [CPU_ID_WIDTH-1:0]     head_cpu;
  logic [BROAD_ID_WIDTH-1:0]   head_id;
  logic head_valid, cpu_in_range, grant_ack, timeout_hit;
  logic [NUM_CPUS-1:0] ack_mask, init_onehot;
  logic [NUM_CPUS*CBUS_CMD_WIDTH-1:0] cmd;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_CNT);
  assign fifo_pop   = (state == ST_POP);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign fifo_push  = bus.broad_fifo_wr_i && (!fifo_full || fifo_pop);

  assign head_addr  = fifo_addr[rd_ptr];
  assign head_type  = fifo_type[rd_ptr];
  assign head_cpu   = fifo_cpu[rd_ptr];
  assign head_id    = fifo_id[rd_ptr];
  assign head_valid = (head_type == TYPE_WR) || (head_type == TYPE_RD);
  assign cpu_in_range = (int'(head_cpu) < NUM_CPUS);

  always_comb begin
    init_onehot = '0;
    for (int i = 0; i < NUM_CPUS; i++)
      init_onehot[i] = cpu_in_range && (int'(head_cpu) == i);
  end

  assign grant_ack = |(bus.cbus_ack_array_i & init_onehot);

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_addr[wr_ptr] <= bus.broad_addr_i;
      fifo_type[wr_ptr] <= bus.broad_type_i;
      fifo_cpu[wr_ptr]  <= bus.broad_cpu_id_i;
      fifo_id[wr_ptr]   <= bus.broad_id_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({fifo_push, fifo_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:
        if (!fifo_empty) state_next = head_valid ? ST_SNOOP : ST_POP;
      ST_SNOOP:
        if (&(ack_mask | bus.cbus_ack_array_i)) state_next = cpu_in_range ? ST_GRANT : ST_POP;
        else if (timeout_hit)                   state_next = ST_POP;
      ST_GRANT:
        if (grant_ack || timeout_hit) state_next = ST_POP;
      default:
        state_next = ST_IDLE;
    endcase
  end

  // Mask is preloaded with the initiator while idle so it is ready on SNOOP entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ack_mask <= '0;
    else begin
      case (state)
        ST_IDLE:  ack_mask <= init_onehot;
        ST_SNOOP: ack_mask <= ack_mask | bus.cbus_ack_array_i;
        default:  ack_mask <= '0;
      endcase
    end
  end

`ifdef MESI_ISC_BROAD_ACK_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] to_cnt;
  logic to_flag, waiting, ack_accept, entering;

  assign waiting    = (state == ST_SNOOP) || (state == ST_GRANT);
  assign ack_accept = (state == ST_SNOOP) ? |(bus.cbus_ack_array_i & ~ack_mask)
                                          : (state == ST_GRANT) && grant_ack;
  assign entering   = ((state_next == ST_SNOOP) || (state_next == ST_GRANT)) &&
                      (state_next != state);
  assign timeout_hit = waiting && (to_cnt == '0) && !ack_accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      if (entering || ack_accept)          to_cnt <= TW'(ACK_TIMEOUT - 1);
      else if (waiting && to_cnt != '0)    to_cnt <= to_cnt - 1'b1;
      to_flag <= timeout_hit;
    end
  end

  assign bus.timeout_err_o = fifo_pop && to_flag;
`else
  assign timeout_hit       = 1'b0;
  assign bus.timeout_err_o = 1'b0;
`endif

  always_comb begin
    cmd = '0;
    for (int i = 0; i < NUM_CPUS; i++) begin
      if (state == ST_SNOOP && !ack_mask[i])
        cmd[i*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = (head_type == TYPE_WR) ? CMD_WR_SNOOP : CMD_RD_SNOOP;
      else if (state == ST_GRANT && init_onehot[i])
        cmd[i*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = (head_type == TYPE_WR) ? CMD_EN_WR : CMD_EN_RD;
    end
  end

  assign bus.cbus_cmd_array_o          = cmd;
  assign bus.cbus_addr_o               = fifo_empty ? '0 : head_addr;
  assign bus.fifo_count_o              = count;
  assign bus.fifo_status_full_o        = fifo_full;
  assign bus.fifo_status_almost_full_o = (count >= ALMOST_CNT);
  assign bus.broad_done_o              = fifo_pop;
  assign bus.broad_done_id_o           = fifo_pop ? head_id : '0;
endmodule
